// File: rtl/sample_pwm_dac.sv
// sample_pwm_dac: 2-deep duty-sample FIFO feeding a frame-based complementary PWM pair with dead-time.
// Latency: pwm_p/pwm_n are registered one cycle after the count/duty compare; a popped sample drives the next frame.
// Backpressure: s_ready = (FIFO not full); a refused sample is held by upstream until a frame-end pop frees a slot.
module sample_pwm_dac #(
    parameter int DW   = 8,
    parameter int DEAD = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          pwm_p,
    output logic          pwm_n,
    output logic          frame_start,
    output logic          underrun
);

    // Last count of a frame: 2^DW-2, so a frame lasts 2^DW-1 cycles.
    localparam logic [DW-1:0] CNT_LAST = {{(DW-1){1'b1}}, 1'b0};
    localparam logic [3:0]    DEAD_L   = 4'(DEAD);

    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] duty_q;
    logic [DW-1:0] fifo_mem_q [2];
    logic          fifo_rd_q, fifo_wr_q;
    logic [1:0]    fifo_cnt_q;
    logic [3:0]    dt_q, dt_d;
    logic          raw, raw_q, en_q;
    logic          pwm_p_q, pwm_n_q, underrun_q;
    logic          load, push, pop;

    assign s_ready     = (fifo_cnt_q != 2'd2);
    assign push        = s_valid && s_ready;
    // A frame-end load only pops what is already stored; a same-cycle push is not bypassed.
    assign load        = en && (cnt_q == CNT_LAST);
    assign pop         = load && (fifo_cnt_q != 2'd0);
    assign raw         = (cnt_q < duty_q);
    assign frame_start = en && !rst && (cnt_q == '0);
    assign pwm_p       = pwm_p_q;
    assign pwm_n       = pwm_n_q;
    assign underrun    = underrun_q;

    // Frame counter: free-runs over one frame while enabled, parked at 0 otherwise.
    always_comb begin
        cnt_d = '0;
        if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + DW'(1);
        end
    end

    // Dead-time: reload on every raw edge and on the first enabled cycle, then count down; cleared when disabled.
    always_comb begin
        dt_d = 4'd0;
        if (en) begin
            if (!en_q || (raw != raw_q)) begin
                dt_d = DEAD_L;
            end else if (dt_q != 4'd0) begin
                dt_d = dt_q - 4'd1;
            end
        end
    end

    // FIFO storage: written on an accepted handshake, no reset needed since pointers/count gate reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[fifo_wr_q] <= s_data;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_rd_q  <= 1'b0;
            fifo_wr_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) begin
                fifo_wr_q <= ~fifo_wr_q;
            end
            if (pop) begin
                fifo_rd_q <= ~fifo_rd_q;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Frame state, duty load, underrun flag and the registered break-before-make output pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            duty_q     <= '0;
            dt_q       <= 4'd0;
            raw_q      <= 1'b0;
            en_q       <= 1'b0;
            pwm_p_q    <= 1'b0;
            pwm_n_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dt_q       <= dt_d;
            raw_q      <= en && raw;
            en_q       <= en;
            pwm_p_q    <= en && (dt_d == 4'd0) && raw;
            pwm_n_q    <= en && (dt_d == 4'd0) && !raw;
            underrun_q <= load && (fifo_cnt_q == 2'd0);
            if (pop) begin
                duty_q <= fifo_mem_q[fifo_rd_q];
            end
        end
    end

endmodule

// File: tb/tb_sample_pwm_dac.sv
// tb_sample_pwm_dac: directed frames with hand-computed per-frame output profiles.
// Latency: frame windows are delimited by frame_start and sampled on the falling edge.
// Backpressure: a queue-driven upstream holds s_valid/s_data until the handshake completes.
module tb_sample_pwm_dac;

    logic       clk = 1'b0;
    logic       rst, en, s_valid;
    logic [7:0] s_data;
    logic       s_ready, pwm_p, pwm_n, frame_start, underrun;

    sample_pwm_dac #(.DW(8), .DEAD(2)) dut (
        .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .pwm_p(pwm_p), .pwm_n(pwm_n),
        .frame_start(frame_start), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Upstream source: presents the queue head and retires it only on a real handshake.
    int   feed_q[$];
    int   n_acc = 0;
    int   acc_cyc = -1;
    logic rdy_s, rst_s;
    initial begin
        s_valid = 1'b0;
        s_data  = 8'd0;
        forever begin
            @(negedge clk);
            rdy_s = s_ready;
            rst_s = rst;
            @(posedge clk);
            #1;
            if (s_valid && rdy_s && !rst_s) begin
                void'(feed_q.pop_front());
                n_acc++;
                acc_cyc = cyc - 1;
            end
            if (feed_q.size() != 0) begin
                s_valid = 1'b1;
                s_data  = 8'(feed_q[0]);
            end else begin
                s_valid = 1'b0;
            end
        end
    end

    // Frame monitor: per-window high/low/dead counts, underrun at window start, overlap and stray pulses.
    int win_p[20], win_n[20], win_z[20], win_ur[20], win_st[20];
    int nwin = 0;
    int cp = 0, cn = 0, cz = 0;
    int overlap = 0, stray_ur = 0;
    bit mon_on = 1'b0;
    always @(negedge clk) begin
        if (pwm_p && pwm_n) overlap++;
        if (underrun && !frame_start) stray_ur++;
        if (mon_on) begin
            if (frame_start) begin
                if (nwin > 0 && nwin <= 20) begin
                    win_p[nwin-1] = cp;
                    win_n[nwin-1] = cn;
                    win_z[nwin-1] = cz;
                end
                if (nwin < 20) begin
                    win_ur[nwin] = underrun;
                    win_st[nwin] = cyc;
                end
                nwin++;
                cp = 0; cn = 0; cz = 0;
            end
            if (pwm_p)      cp++;
            else if (pwm_n) cn++;
            else            cz++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_win(input int n);
        int b;
        b = 0;
        while (nwin < n && b < 3000) begin
            @(negedge clk);
            #1;
            b++;
        end
        check_eq($sformatf("wait_win%0d", n), int'(nwin >= n), 1);
    endtask

    // Expected per-window profiles; -1 marks a field not compared for that window.
    int exp_p [18] = '{0, 126, 62, 30, -1, 30, 198, 8, 252, 1, 252, 1, 0, 0, 75, 0, 97, -1};
    int exp_n [18] = '{252, 125, 189, 221, -1, 220, 53, 243, 1, 252, 1, 252, 255, 255, -1, 252, 154, -1};
    int exp_z [18] = '{3, 4, 4, 4, -1, 5, 4, 4, 2, 2, 2, 2, 0, 0, -1, 3, 4, -1};
    int exp_ur[18] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1};

    int e0, b;

    initial begin
        // Reset with en and a pending handshake held high.
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_eq("rst_s_ready", s_ready, 1);
        check_eq("rst_pwm_p", pwm_p, 0);
        check_eq("rst_pwm_n", pwm_n, 0);
        check_eq("rst_frame_start", frame_start, 0);
        check_eq("rst_underrun", underrun, 0);

        // Three back-to-back samples while disabled: only two fit.
        tick();
        rst = 1'b0;
        en  = 1'b0;
        feed_q.push_back(128);
        feed_q.push_back(64);
        feed_q.push_back(32);
        repeat (6) tick();
        @(negedge clk);
        check_eq("acc_while_off", n_acc, 2);
        check_eq("ready_full", s_ready, 0);

        // Enable: first cycle is a frame start without underrun.
        tick();
        en = 1'b1;
        mon_on = 1'b1;
        e0 = cyc;
        @(negedge clk);
        #1;
        check_eq("fs_first", frame_start, 1);
        check_eq("ur_first", underrun, 0);
        b = 0;
        while (n_acc < 3 && b < 400) begin
            tick();
            b++;
        end
        check_eq("third_accept_offset", acc_cyc - e0, 255);

        // Abort frame 5 at cnt=100, stay off 10 cycles, then resume.
        wait_win(5);
        feed_q.push_back(200);
        feed_q.push_back(10);
        while (cyc < win_st[4] + 100) tick();
        en = 1'b0;
        tick();
        @(negedge clk);
        check_eq("off_pwm_p", pwm_p, 0);
        check_eq("off_pwm_n", pwm_n, 0);
        check_eq("off_frame_start", frame_start, 0);
        check_eq("off_fifo_kept", s_ready, 0);
        repeat (8) tick();
        tick();
        en = 1'b1;
        @(negedge clk);
        #1;
        check_eq("fs_reen", frame_start, 1);
        check_eq("ur_reen", underrun, 0);
        feed_q.push_back(255);
        feed_q.push_back(0);
        feed_q.push_back(255);
        feed_q.push_back(0);

        // Push exactly on the load cycle of an empty-FIFO frame.
        wait_win(13);
        while (cyc < win_st[12] + 253) tick();
        @(negedge clk);
        feed_q.push_back(77);
        wait_win(14);
        check_eq("push_at_load_cycle", acc_cyc, win_st[12] + 254);

        // Reset mid-frame with a full FIFO and a held sample.
        wait_win(15);
        feed_q.push_back(50);
        feed_q.push_back(60);
        feed_q.push_back(99);
        while (cyc < win_st[14] + 100) tick();
        rst = 1'b1;
        mon_on = 1'b0;
        tick();
        @(negedge clk);
        check_eq("in_rst_s_ready", s_ready, 1);
        check_eq("in_rst_pwm_p", pwm_p, 0);
        check_eq("in_rst_pwm_n", pwm_n, 0);
        check_eq("in_rst_frame_start", frame_start, 0);
        tick();
        @(negedge clk);
        check_eq("in_rst_s_ready2", s_ready, 1);
        tick();
        rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        #1;
        check_eq("post_rst_s_ready", s_ready, 1);
        check_eq("post_rst_fs", frame_start, 1);
        check_eq("post_rst_ur", underrun, 0);
        wait_win(18);

        for (int i = 0; i < 18; i++) begin
            if (exp_p[i] >= 0) check_eq($sformatf("win%0d_p_high", i + 1), win_p[i], exp_p[i]);
            if (exp_n[i] >= 0) check_eq($sformatf("win%0d_n_high", i + 1), win_n[i], exp_n[i]);
            if (exp_z[i] >= 0) check_eq($sformatf("win%0d_both_low", i + 1), win_z[i], exp_z[i]);
            check_eq($sformatf("win%0d_underrun", i + 1), win_ur[i], exp_ur[i]);
        end
        check_eq("frame_period", win_st[1] - win_st[0], 255);
        check_eq("frame_period_reen", win_st[6] - win_st[5], 255);
        check_eq("overlap_cycles", overlap, 0);
        check_eq("stray_underrun", stray_ur, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_pwm_dac.md
SAMPLE_PWM_DAC -- requirements
Module: sample_pwm_dac

Interface
REQ-001 SHALL have parameter DW, default 8, meaning sample width in bits; frame period is 2^DW-1 cycles.
REQ-002 SHALL have parameter DEAD, default 2, meaning dead-time cycles (1..15) between complementary output edges.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  run enable.
REQ-006 SHALL have port s_data  input  DW  unsigned sine sample (duty code).
REQ-007 SHALL have port s_valid  input  1  upstream sample valid.
REQ-008 SHALL have port s_ready  output  1  block can accept a sample.
REQ-009 SHALL have port pwm_p  output  1  PWM output, registered.
REQ-010 SHALL have port pwm_n  output  1  complementary PWM output, registered.
REQ-011 SHALL have port frame_start  output  1  one-cycle pulse at the start of each frame.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse when a frame starts with no buffered sample.

Function
REQ-013 SHALL hold a 2-entry FIFO of samples; s_ready = (fifo count != 2), combinational from the count.
REQ-014 SHALL push s_data when s_valid && s_ready; a push with s_valid high and s_ready low SHALL be ignored, and upstream holds data.
REQ-015 SHALL run frame counter cnt over 0..2^DW-2 while en=1, wrapping 2^DW-2 -> 0; while en=0, cnt SHALL be held at 0.
REQ-016 SHALL perform a load event on each cycle with en=1 and cnt=2^DW-2; if the FIFO is non-empty, pop the head into duty_q, effective from cnt=0 of the next frame.
REQ-017 At a load event with an empty FIFO, SHALL keep duty_q unchanged and pulse underrun in the following cycle (aligned with frame_start).
REQ-018 Push and pop in the same cycle SHALL leave count unchanged. With the FIFO empty, the pop SHALL see empty (no bypass), flag underrun, and store the pushed sample.
REQ-019 SHALL compute raw = (cnt < duty_q): duty 0 gives always low, duty 2^DW-1 gives always high, and duty D gives exactly D high cycles per frame.
REQ-020 SHALL reload a dead-time counter to DEAD on every raw transition, decrement it to 0, and force pwm_p=0 and pwm_n=0 while it is non-zero.
REQ-021 Otherwise SHALL drive pwm_p = raw and pwm_n = ~raw; both outputs SHALL be registered, with one cycle latency from raw.
REQ-022 SHALL never drive pwm_p and pwm_n high in the same cycle.
REQ-023 SHALL pulse frame_start for one cycle whenever en=1 and cnt=0, including the first enabled cycle.
REQ-024 Dropping en mid-frame SHALL abort the frame: cnt=0, pwm_p=pwm_n=0, and the dead-time counter is cleared on the next edge; FIFO contents and duty_q SHALL be retained and pushes still accepted.
REQ-025 When en rises, SHALL start the frame at cnt=0 with the retained duty_q; no load occurs until the end of that frame.

Reset
REQ-026 While rst=1 on an edge, SHALL set cnt=0, FIFO count=0, duty_q=0, dead-time counter=0, pwm_p=0, pwm_n=0, frame_start=0, underrun=0.
REQ-027 s_ready SHALL read 1 during and after reset; rst SHALL take priority over en and over the handshake.
REQ-028 Reset asserted mid-frame SHALL discard buffered samples; the first frame after reset uses duty 0.

Verification
REQ-029 Reset, en=1, no samples -> frame_start every 255 cycles, underrun pulse at each frame start after the first, pwm_p=0 and pwm_n=1 throughout after the initial dead time.
REQ-030 Push 128, then 64 -> frame 2 shows 128 pwm_p-high cycles minus dead-time edges, frame 3 shows 64; each transition shows DEAD cycles with both outputs low; no overlap ever.
REQ-031 Push 3 samples back-to-back with en=0 -> s_ready goes 0 after 2 accepts, the third is held by upstream, and it is accepted one cycle after the first load event once en=1.
REQ-032 Duty 0 and 255 alternating -> full-low and full-high frames; no dead time inside constant frames; dead time at frame boundaries only.
REQ-033 Push on the same cycle as a load event with the FIFO empty -> underrun pulses, duty_q unchanged, and the sample is used in the following frame.
REQ-034 Drop en at cnt=100, then raise it 10 cycles later -> outputs low next edge, frame_start on re-enable, same duty_q, FIFO count preserved.
